// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter that puts I-cache and D-cache miss/writeback
// traffic onto one main-memory port. It also counts contended idle cycles.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              busy,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            r_state, w_state;
  logic              r_owner, w_owner;  // 0 = I side, 1 = D side
  logic              r_wr, w_wr;
  logic              r_last, w_last;    // side granted most recently
  logic              r_mem_rd, w_mem_rd;
  logic              r_mem_wr, w_mem_wr;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [DATA_W-1:0] r_rdata, w_rdata;
  logic              r_i_done, w_i_done;
  logic              r_d_done, w_d_done;
  logic              r_busy, w_busy;
  logic [CNT_W-1:0]  r_cnt, w_cnt;

  logic              w_conflict;
  logic              w_grant_d;
  req_t              w_sel;

  assign w_conflict = i_req & d_req;
  // On contention the side that did not win last time gets the port.
  assign w_grant_d  = d_req & (~i_req | ~r_last);
  assign w_sel      = w_grant_d ? {d_wr, d_addr, d_wdata} : {i_wr, i_addr, i_wdata};

  always_comb begin
    w_state  = r_state;
    w_owner  = r_owner;
    w_wr     = r_wr;
    w_last   = r_last;
    w_mem_rd = r_mem_rd;
    w_mem_wr = r_mem_wr;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_rdata  = '0;
    w_i_done = 1'b0;
    w_d_done = 1'b0;
    w_cnt    = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_mem_rd = 1'b0;
        w_mem_wr = 1'b0;
        if (w_conflict && !(&r_cnt)) w_cnt = r_cnt + 1'b1;
        if (i_req | d_req) begin
          w_owner  = w_grant_d;
          w_last   = w_grant_d;
          w_wr     = w_sel.wr;
          w_addr   = w_sel.addr;
          w_wdata  = w_sel.wdata;
          w_mem_rd = ~w_sel.wr;
          w_mem_wr = w_sel.wr;
          w_state  = MEM;
        end
      end
      MEM: begin
        if (mem_done) begin
          w_mem_rd = 1'b0;
          w_mem_wr = 1'b0;
          w_rdata  = r_wr ? '0 : mem_rdata;
          w_i_done = ~r_owner;
          w_d_done = r_owner;
          w_state  = DONE;
        end
      end
      DONE: w_state = IDLE;
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_wr     <= 1'b0;
      r_last   <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state;
      r_owner  <= w_owner;
      r_wr     <= w_wr;
      r_last   <= w_last;
      r_mem_rd <= w_mem_rd;
      r_mem_wr <= w_mem_wr;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_rdata  <= w_rdata;
      r_i_done <= w_i_done;
      r_d_done <= w_d_done;
      r_busy   <= w_busy;
      r_cnt    <= w_cnt;
    end
  end

  assign mem_rd       = r_mem_rd;
  assign mem_wr       = r_mem_wr;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign rdata        = r_rdata;
  assign i_done       = r_i_done;
  assign d_done       = r_d_done;
  assign busy         = r_busy;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus contention,
// round-robin, reset-abort and counter-saturation sequences.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_req, i_wr, d_req, d_wr, mem_done;
  logic [15:0] i_addr, i_wdata, d_addr, d_wdata, mem_rdata;
  logic        i_done, d_done, mem_rd, mem_wr, busy;
  logic [15:0] rdata, mem_addr, mem_wdata, conflict_cnt;
  logic        s_i_done, s_d_done, s_mem_rd, s_mem_wr, s_busy;
  logic [15:0] s_rdata, s_mem_addr, s_mem_wdata;
  logic [1:0]  s_cnt;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .busy(busy), .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter copy fed the same stimulus; only its counter is checked.
  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata), .i_done(s_i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(s_d_done),
    .rdata(s_rdata), .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .busy(s_busy), .conflict_cnt(s_cnt)
  );

  typedef struct {
    logic        side_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] mrd;
    logic [15:0] exp_rdata;
    int          exp_done;  // 1 = i_done, 2 = d_done
  } vec_t;

  vec_t tbl[6];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, mcnt = 0, lat = 1;
  logic [15:0] mrd;
  int i_rem = 0, d_rem = 0;
  bit i_gap = 0, d_gap = 0, prev_s = 0;
  int dlog[16];
  int dn, sn, scyc, hold_err, done_cyc;
  logic [15:0] s_addr_log[16], s_wdata_log[16], done_rdata;
  logic        s_wr_log[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    dn = 0; sn = 0; scyc = 0; hold_err = 0; done_cyc = -1; done_rdata = '0;
  endtask

  // One cycle: memory responder and requester models react to what the DUT shows.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (mem_rd | mem_wr) begin
      scyc++;
      if (!prev_s) begin
        if (sn < 16) begin
          s_addr_log[sn] = mem_addr; s_wdata_log[sn] = mem_wdata; s_wr_log[sn] = mem_wr;
        end
        sn++;
      end else if (sn > 0 && sn <= 16) begin
        if (mem_addr !== s_addr_log[sn-1] || mem_wdata !== s_wdata_log[sn-1]) hold_err++;
      end
      mcnt++;
      if (mcnt >= lat) begin mem_done = 1'b1; mem_rdata = mrd; mcnt = 0; end
      else begin mem_done = 1'b0; mem_rdata = 16'hDEAD; end
    end else begin
      mem_done = 1'b0; mem_rdata = 16'hDEAD; mcnt = 0;
    end
    prev_s = mem_rd | mem_wr;
    if (i_done | d_done) begin
      if (dn < 16) dlog[dn] = (i_done ? 1 : 0) + (d_done ? 2 : 0);
      dn++;
      done_rdata = rdata;
      done_cyc = cyc;
    end
    if (i_done) begin i_req = 1'b0; i_rem--; i_gap = 1'b1; end
    else if (i_gap) begin i_gap = 1'b0; if (i_rem > 0) i_req = 1'b1; end
    if (d_done) begin d_req = 1'b0; d_rem--; d_gap = 1'b1; end
    else if (d_gap) begin d_gap = 1'b0; if (d_rem > 0) d_req = 1'b1; end
  endtask

  task automatic wait_all(input string name, input int bound);
    int start;
    start = cyc;
    while ((i_rem > 0 || d_rem > 0) && (cyc - start) < bound) step();
    chk({name, "_timeout"}, 32'((i_rem > 0) || (d_rem > 0)), 32'd0);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_rem = 0; d_rem = 0;
    i_gap = 1'b0; d_gap = 1'b0; mem_done = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; mcnt = 0; prev_s = 1'b0;
  endtask

  task automatic run_txn(input int k);
    vec_t v;
    int start;
    v = tbl[k];
    clr();
    lat = v.lat; mrd = v.mrd;
    if (v.side_d) begin
      d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1; d_rem = 1;
    end else begin
      i_wr = v.wr; i_addr = v.addr; i_wdata = v.wdata; i_req = 1'b1; i_rem = 1;
    end
    start = cyc;
    wait_all($sformatf("v%0d", k), 40);
    chk($sformatf("v%0d_strobe_cycles", k), 32'(scyc), 32'(v.lat));
    chk($sformatf("v%0d_grants", k), 32'(sn), 32'd1);
    chk($sformatf("v%0d_kind_wr", k), 32'(s_wr_log[0]), 32'(v.wr));
    chk($sformatf("v%0d_mem_addr", k), 32'(s_addr_log[0]), 32'(v.addr));
    chk($sformatf("v%0d_mem_wdata", k), 32'(s_wdata_log[0]), 32'(v.wdata));
    chk($sformatf("v%0d_hold", k), 32'(hold_err), 32'd0);
    chk($sformatf("v%0d_done_cnt", k), 32'(dn), 32'd1);
    chk($sformatf("v%0d_done_side", k), 32'(dlog[0]), 32'(v.exp_done));
    chk($sformatf("v%0d_rdata", k), 32'(done_rdata), 32'(v.exp_rdata));
    chk($sformatf("v%0d_done_latency", k), 32'(done_cyc - start), 32'(v.lat + 1));
    chk($sformatf("v%0d_after", k), 32'({busy, i_done, d_done, mem_rd, mem_wr}), 32'd0);
    chk($sformatf("v%0d_rdata_clr", k), 32'(rdata), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          side wr   addr      wdata     lat mrd       exp_rdata done
    tbl[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 4, 16'h1234, 16'h1234, 1};
    tbl[1] = '{1'b1, 1'b0, 16'h8001, 16'h5555, 1, 16'hA5A5, 16'hA5A5, 2};
    tbl[2] = '{1'b0, 1'b1, 16'h00FF, 16'hCAFE, 2, 16'h7777, 16'h0000, 1};
    tbl[3] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 3, 16'h1111, 16'h0000, 2};
    tbl[4] = '{1'b0, 1'b0, 16'h1000, 16'h2468, 6, 16'hFFFF, 16'hFFFF, 1};
    tbl[5] = '{1'b0, 1'b0, 16'h0077, 16'h0000, 2, 16'h4242, 16'h4242, 1};

    i_wr = 0; i_addr = 0; i_wdata = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 16'hDEAD; mrd = 16'h0;
    do_reset();

    // Reset state and idle, with stray mem_done pulses that must be ignored.
    chk("rst_ctl", 32'({i_done, d_done, busy, mem_rd, mem_wr}), 32'd0);
    chk("rst_addr_rdata", {mem_addr, rdata}, 32'd0);
    chk("rst_wdata_cnt", {mem_wdata, conflict_cnt}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      mem_done = (k >= 5);
      @(negedge clk);
      chk("idle_ctl", 32'({i_done, d_done, busy, mem_rd, mem_wr}), 32'd0);
    end
    mem_done = 1'b0;
    chk("idle_data", {mem_addr, rdata}, 32'd0);

    for (int k = 0; k < 5; k++) run_txn(k);

    // Simultaneous requests after reset: D wins the first conflict.
    do_reset();
    clr();
    lat = 2; mrd = 16'h3C3C;
    d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
    i_wr = 1'b0; i_addr = 16'h0002; i_wdata = 16'h0000;
    i_req = 1'b1; d_req = 1'b1; i_rem = 1; d_rem = 1;
    wait_all("pair", 60);
    chk("pair_grants", 32'(sn), 32'd2);
    chk("pair_first", {15'd0, s_wr_log[0], s_addr_log[0]}, {15'd0, 1'b1, 16'h0100});
    chk("pair_first_wdata", 32'(s_wdata_log[0]), 32'h0000BEEF);
    chk("pair_second", {15'd0, s_wr_log[1], s_addr_log[1]}, {15'd0, 1'b0, 16'h0002});
    chk("pair_order", 32'({dlog[0][1:0], dlog[1][1:0]}), 32'b1001);
    chk("pair_rdata", 32'(done_rdata), 32'h00003C3C);
    chk("pair_cnt", 32'(conflict_cnt), 32'd1);
    chk("pair_cnt2", 32'(s_cnt), 32'd1);

    // Continuous contention: each side re-requests right after its done.
    clr();
    lat = 1; mrd = 16'h0F0F;
    i_wr = 1'b0; i_addr = 16'h0A0A; d_wr = 1'b0; d_addr = 16'h0D0D;
    i_req = 1'b1; d_req = 1'b1; i_rem = 2; d_rem = 2;
    wait_all("rr", 80);
    chk("rr_done_cnt", 32'(dn), 32'd4);
    chk("rr_order", 32'({dlog[0][1:0], dlog[1][1:0], dlog[2][1:0], dlog[3][1:0]}),
        32'b10011001);
    chk("rr_addr0", 32'(s_addr_log[0]), 32'h00000D0D);
    chk("rr_addr1", 32'(s_addr_log[1]), 32'h00000A0A);
    chk("rr_addr2", 32'(s_addr_log[2]), 32'h00000D0D);
    chk("rr_addr3", 32'(s_addr_log[3]), 32'h00000A0A);
    chk("rr_cnt", 32'(conflict_cnt), 32'd4);
    chk("rr_cnt2_sat", 32'(s_cnt), 32'd3);

    // After a lone D grant, the next conflict goes to I.
    clr();
    lat = 1; d_wr = 1'b1; d_addr = 16'h0E0E; d_wdata = 16'h1357;
    d_req = 1'b1; d_rem = 1;
    wait_all("dsolo", 20);
    clr();
    d_wr = 1'b0; d_addr = 16'h0222; i_wr = 1'b0; i_addr = 16'h0111;
    i_req = 1'b1; d_req = 1'b1; i_rem = 1; d_rem = 1;
    wait_all("rr2", 40);
    chk("rr2_order", 32'({dlog[0][1:0], dlog[1][1:0]}), 32'b0110);
    chk("rr2_first_addr", 32'(s_addr_log[0]), 32'h00000111);
    chk("rr2_cnt", 32'(conflict_cnt), 32'd5);
    chk("rr2_cnt2_sat", 32'(s_cnt), 32'd3);

    // Reset while a read is outstanding abandons it silently.
    clr();
    lat = 10; mrd = 16'h9999;
    i_wr = 1'b0; i_addr = 16'h0033; i_req = 1'b1; i_rem = 1;
    repeat (3) step();
    chk("mid_mem_rd", 32'({mem_rd, busy}), 32'b11);
    rst = 1'b1; i_req = 1'b0; i_rem = 0; i_gap = 1'b0;
    step();
    rst = 1'b0;
    chk("abort_ctl", 32'({i_done, d_done, busy, mem_rd, mem_wr}), 32'd0);
    chk("abort_addr_cnt", {mem_addr, conflict_cnt}, 32'd0);
    chk("abort_cnt2", 32'(s_cnt), 32'd0);
    repeat (4) step();
    chk("abort_no_done", 32'(dn), 32'd0);
    run_txn(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
